// File: rtl/interface_hcsr04.sv
// interface_hcsr04 -- HC-SR04 ultrasonic sensor front end.
//
// Drives the sensor trigger pulse, times the echo pulse and converts the
// echo width to whole centimetres as 3-digit BCD, rounded to the nearest cm.
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   medir     in   measurement request (level; starts on its rising edge)
//   echo      in   raw sensor echo, asynchronous to clock
//   trigger   out  sensor trigger pulse, CICLOS_TRIGGER cycles wide
//   medida    out  distance {hundreds,tens,units} BCD cm, registered
//   pronto    out  one-cycle pulse when a measurement finishes
//   erro      out  last measurement timed out; cleared when the next starts
//   db_estado out  current FSM state code (debug)
module interface_hcsr04 #(
    parameter int CICLOS_TRIGGER = 500,
    parameter int CICLOS_POR_CM  = 2941,
    parameter int CICLOS_TIMEOUT = 1_250_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int CNT_MAX = (CICLOS_TIMEOUT > CICLOS_TRIGGER) ? CICLOS_TIMEOUT : CICLOS_TRIGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SUB_W   = $clog2(CICLOS_POR_CM + 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDE          = 4'd4,
        ARMAZENA      = 4'd5,
        FINAL         = 4'd6
    } estado_t;

    estado_t            estado, prox;
    logic               echo_m, echo_s;
    logic               medir_r, medir_q;
    logic               start;
    logic               fim_tmo;
    logic [CNT_W-1:0]   cont;
    logic [SUB_W-1:0]   sub;
    logic [11:0]        cm;

    // BCD increment of a 3-digit value, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] c, d, u;
        c = v[11:8];
        d = v[7:4];
        u = v[3:0];
        if (v == 12'h999) return v;
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (d != 4'd9) begin
                d = d + 4'd1;
            end else begin
                d = 4'd0;
                c = c + 4'd1;
            end
        end
        return {c, d, u};
    endfunction

    // echo is fully asynchronous: two-flop synchroniser. medir only needs
    // an edge detector, so it is registered once plus one delay stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_m  <= 1'b0;
            echo_s  <= 1'b0;
            medir_r <= 1'b0;
            medir_q <= 1'b0;
        end else begin
            echo_m  <= echo;
            echo_s  <= echo_m;
            medir_r <= medir;
            medir_q <= medir_r;
        end
    end

    assign start = medir_r & ~medir_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= prox;
    end

    // Echo takes priority over the timeout in both waiting states, so a
    // pulse that ends exactly on the last allowed cycle is still stored.
    always_comb begin
        prox    = estado;
        fim_tmo = 1'b0;
        case (estado)
            INICIAL:       if (start) prox = PREPARA;
            PREPARA:       prox = ENVIA_TRIGGER;
            ENVIA_TRIGGER: if (cont == CNT_W'(CICLOS_TRIGGER - 1)) prox = ESPERA_ECHO;
            ESPERA_ECHO: begin
                if (echo_s) begin
                    prox = MEDE;
                end else if (cont == CNT_W'(CICLOS_TIMEOUT - 1)) begin
                    prox    = FINAL;
                    fim_tmo = 1'b1;
                end
            end
            MEDE: begin
                if (!echo_s) begin
                    prox = ARMAZENA;
                end else if (cont == CNT_W'(CICLOS_TIMEOUT - 1)) begin
                    prox    = FINAL;
                    fim_tmo = 1'b1;
                end
            end
            ARMAZENA:      prox = FINAL;
            FINAL:         prox = INICIAL;
            default:       prox = INICIAL;
        endcase
    end

    // One counter serves trigger width and both timeouts; it restarts on
    // every state change so each timed state starts counting from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont <= '0;
        end else if (prox != estado) begin
            cont <= '0;
        end else if (estado inside {ENVIA_TRIGGER, ESPERA_ECHO, MEDE}) begin
            cont <= cont + 1'b1;
        end
    end

    // Echo width datapath: sub counts cycles within the current cm, cm is
    // the BCD count of whole centimetres. medida is written only in
    // ARMAZENA, so it is stable while pronto is high and untouched on timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sub    <= '0;
            cm     <= '0;
            medida <= '0;
            erro   <= 1'b0;
        end else begin
            case (estado)
                PREPARA: begin
                    sub  <= '0;
                    cm   <= '0;
                    erro <= 1'b0;
                end
                MEDE: begin
                    if (echo_s) begin
                        if (sub == SUB_W'(CICLOS_POR_CM - 1)) begin
                            sub <= '0;
                            cm  <= bcd_inc(cm);
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                end
                ARMAZENA: medida <= (sub < SUB_W'(CICLOS_POR_CM / 2)) ? cm : bcd_inc(cm);
                default: ;
            endcase
            if (fim_tmo) erro <= 1'b1;
        end
    end

    assign trigger   = (estado == ENVIA_TRIGGER);
    assign pronto    = (estado == FINAL);
    assign db_estado = estado;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Testbench for interface_hcsr04 with shortened timing parameters.
// Main instance: trigger 5, 20 cycles/cm, timeout 600.
// Second instance: 2 cycles/cm, timeout 4000, for BCD saturation.
module tb_interface_hcsr04;

    localparam int P_TRIG = 5;
    localparam int P_CM   = 20;
    localparam int P_TMO  = 600;
    localparam int S_TRIG = 5;
    localparam int S_CM   = 2;
    localparam int S_TMO  = 4000;

    logic        clock = 1'b0;
    logic        reset;
    logic        medir, echo, medir2, echo2;
    logic        trigger, pronto, erro, trigger2, pronto2, erro2;
    logic [11:0] medida, medida2;
    logic [3:0]  db_estado, db_estado2;

    always #5 clock = ~clock;

    interface_hcsr04 #(.CICLOS_TRIGGER(P_TRIG), .CICLOS_POR_CM(P_CM), .CICLOS_TIMEOUT(P_TMO)) dut (
        .clock(clock), .reset(reset), .medir(medir), .echo(echo), .trigger(trigger),
        .medida(medida), .pronto(pronto), .erro(erro), .db_estado(db_estado)
    );

    interface_hcsr04 #(.CICLOS_TRIGGER(S_TRIG), .CICLOS_POR_CM(S_CM), .CICLOS_TIMEOUT(S_TMO)) dut_sat (
        .clock(clock), .reset(reset), .medir(medir2), .echo(echo2), .trigger(trigger2),
        .medida(medida2), .pronto(pronto2), .erro(erro2), .db_estado(db_estado2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [11:0] medida;
        logic        erro;
        int          delay;   // cycles from trigger fall to pronto, -1 = don't care
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] model_last = 12'h000;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // n = echo-high cycles counted while measuring; p = cycles per cm.
    function automatic exp_t model(input int n, input bit got_echo, input logic [11:0] last,
                                   input int p, input int t);
        exp_t e;
        int   cmv;
        if (!got_echo || n >= t) begin
            e.medida = last;
            e.erro   = 1'b1;
            e.delay  = got_echo ? -1 : t;
        end else begin
            cmv = n / p + (((n % p) >= p / 2) ? 1 : 0);
            if (cmv > 999) cmv = 999;
            e.medida = to_bcd(cmv);
            e.erro   = 1'b0;
            e.delay  = -1;
        end
        return e;
    endfunction

    // ---------------- compare process ----------------
    int          cyc = 0, fall_cyc = 0, trig_len = 0;
    logic        trig_prev = 1'b0;
    logic [11:0] med_prev  = 12'h000;

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            trig_len  = 0;
            trig_prev = 1'b0;
            med_prev  = medida;
        end else begin
            cyc++;
            if (trigger) begin
                trig_len++;
            end else if (trig_prev) begin
                check("trigger_width", trig_len, P_TRIG);
                trig_len = 0;
                fall_cyc = cyc;
            end
            if (medida !== med_prev) check("medida_changes_only_with_pronto", pronto, 1);
            check("medida_is_bcd", (medida[11:8] <= 9) && (medida[7:4] <= 9) && (medida[3:0] <= 9), 1);
            if (pronto) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pronto", pronto, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("model_medida", medida, e.medida);
                    check("model_erro", erro, e.erro);
                    if (e.delay >= 0) check("pronto_latency", cyc - fall_cyc, e.delay);
                end
            end
            trig_prev = trigger;
            med_prev  = medida;
        end
    end

    // ---------------- sat-instance monitors ----------------
    int   npronto2 = 0, ntrig2 = 0;
    logic trig2_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (pronto2) npronto2++;
            if (trigger2 && !trig2_prev) ntrig2++;
        end
        trig2_prev = trigger2;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return trigger;
            1:       return pronto;
            2:       return trigger2;
            default: return pronto2;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input logic val, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            if (get_sig(sel) === val) break;
            @(posedge clock); #1;
        end
        if (i == lim) begin
            total++;
            bad++;
            $display("FAIL %s: timed out after %0d cycles, expected %0b", name, lim, val);
        end
    endtask

    task automatic start_req();
        @(posedge clock); #1 medir = 1'b1;
    endtask

    // Echo of w raw cycles launched right after the trigger falls; w-1 of
    // those cycles are counted (the first one is where the echo is detected).
    task automatic run_echo(input int w, input bit pre_pulse);
        bit seen = 0;
        wait_for("trigger_rise", 0, 1'b1, 50);
        if (pre_pulse) begin
            echo = 1'b1;
            @(posedge clock); #1 echo = 1'b0;
        end
        wait_for("trigger_fall", 0, 1'b0, P_TRIG + 10);
        echo = (w > 0);
        for (int i = 0; i < w; i++) begin
            @(posedge clock); #1;
            if (pronto) seen = 1;
        end
        echo = 1'b0;
        if (!seen) wait_for("pronto", 1, 1'b1, P_TMO + 50);
        @(posedge clock); #1 medir = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic measure(input int w, input bit pre_pulse);
        exp_t e;
        e = model(w - 1, w > 0, model_last, P_CM, P_TMO);
        exp_q.push_back(e);
        model_last = e.medida;
        start_req();
        run_echo(w, pre_pulse);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        exp_t e;
        reset = 1'b1; medir = 1'b0; echo = 1'b0; medir2 = 1'b0; echo2 = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_trigger", trigger, 0);
        check("rst_medida", medida, 12'h000);
        check("rst_pronto", pronto, 0);
        check("rst_erro", erro, 0);
        check("rst_estado", db_estado, 0);
        check("rst_sat_medida", medida2, 12'h000);

        // Hand-computed pins on the model (20 cycles/cm, timeout 600).
        e = model(199, 1, 12'h000, P_CM, P_TMO);  check("pin_199", e.medida, 12'h010);
        e = model(10, 1, 12'h000, P_CM, P_TMO);   check("pin_10", e.medida, 12'h001);
        e = model(2199, 1, 12'h000, S_CM, S_TMO); check("pin_sat", e.medida, 12'h999);

        // Request already high at reset release: state must not move before edge 2.
        e = model(199, 1, model_last, P_CM, P_TMO);
        exp_q.push_back(e);
        model_last = e.medida;
        medir = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 check("release_edge1_state", db_estado, 0);
        @(posedge clock); #1 check("release_edge2_state", db_estado, 1);
        run_echo(200, 0);
        check("t2_medida_010", medida, 12'h010);
        check("t2_erro", erro, 0);

        // Half-cm rounding boundary; first one also carries an echo blip
        // during the trigger that must be ignored.
        measure(10, 1);
        check("t3_1469_medida", medida, 12'h000);
        measure(11, 0);
        check("t3_1470_medida", medida, 12'h001);

        // No echo: timeout from ESPERA_ECHO, medida held, erro held afterwards.
        measure(0, 0);
        check("t4_medida_held", medida, 12'h001);
        check("t4_erro_held", erro, 1);

        // Echo longer than timeout, then a normal 20 cm measurement.
        measure(650, 0);
        check("t5_tmo_erro", erro, 1);
        check("t5_tmo_medida", medida, 12'h001);
        measure(400, 0);
        check("t5_medida_020", medida, 12'h020);
        check("t5_erro_cleared", erro, 0);

        // Asynchronous reset in the middle of the trigger pulse.
        start_req();
        wait_for("rst_trig_rise", 0, 1'b1, 50);
        #2 reset = 1'b0;
        #1;
        check("async_rst_trigger", trigger, 0);
        check("async_rst_medida", medida, 12'h000);
        check("async_rst_estado", db_estado, 0);
        check("async_rst_pronto", pronto, 0);
        medir = 1'b0;
        model_last = 12'h000;
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        measure(200, 0);
        check("after_rst_medida", medida, 12'h010);

        // Saturation with medir toggling mid-measurement.
        npronto2 = 0;
        ntrig2   = 0;
        @(posedge clock); #1 medir2 = 1'b1;
        wait_for("sat_trig_rise", 2, 1'b1, 50);
        wait_for("sat_trig_fall", 2, 1'b0, S_TRIG + 10);
        echo2 = 1'b1;
        for (int i = 0; i < 2200; i++) begin
            @(posedge clock); #1;
            if (i == 500) medir2 = 1'b0;
            if (i == 600) medir2 = 1'b1;
        end
        echo2 = 1'b0;
        wait_for("sat_pronto", 3, 1'b1, 50);
        check("sat_medida_999", medida2, 12'h999);
        check("sat_erro", erro2, 0);
        repeat (30) @(posedge clock);
        #1;
        check("sat_single_pronto", npronto2, 1);
        check("sat_single_trigger", ntrig2, 1);
        check("sat_medida_stable", medida2, 12'h999);
        check("model_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "global timeout");
    end

endmodule
